// File: rtl/mc_control_fsm_pkg.sv
// mc_ctrl_pkg: shared constants and types for the multi-cycle control unit.
// Holds opcode/func codes, ALU function encodings, mux-select encodings,
// the FSM state enum and the decoded instruction-class enum.
package mc_ctrl_pkg;

  // Primary opcodes (inst[WORD_SIZE-1 -: 4])
  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_ALU = 4'd15;

  // Special func codes under OP_ALU (func values below 8 are ALU ops)
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;
  localparam logic [5:0] FN_ALU_LIMIT = 6'd8;

  // ALU function encodings, identical to func[2:0] of R-type ALU ops
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_NOT = 3'd4;
  localparam logic [2:0] ALU_TCP = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  // Register-file destination select
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_R2 = 2'd2;

  // ALU operand-B select
  localparam logic [1:0] SB_B    = 2'd0;
  localparam logic [1:0] SB_ONE  = 2'd1;
  localparam logic [1:0] SB_IMM  = 2'd2;
  localparam logic [1:0] SB_ZERO = 2'd3;

  typedef enum logic [2:0] {
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_RALU,
    CLS_ADI,
    CLS_ORI,
    CLS_LHI,
    CLS_LWD,
    CLS_SWD,
    CLS_BRANCH,
    CLS_JMP,
    CLS_JAL,
    CLS_JPR,
    CLS_JRL,
    CLS_WWD,
    CLS_HLT,
    CLS_UNDEF
  } inst_class_t;

  // Classes that need the EX stage; everything else finishes in ID.
  function automatic logic classUsesEx(input inst_class_t cls);
    case (cls)
      CLS_RALU, CLS_ADI, CLS_ORI, CLS_LHI,
      CLS_LWD, CLS_SWD, CLS_BRANCH: classUsesEx = 1'b1;
      default:                      classUsesEx = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: instruction/ALU inputs, memory handshake and datapath
// strobes between the control unit (master) and the datapath/memory (slave).
interface mc_control_fsm_if #(
  parameter int WORD_SIZE = 16
) ();

  logic [WORD_SIZE-1:0] inst;
  logic [WORD_SIZE-1:0] bcond;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 pc_write;
  logic                 ir_write;
  logic                 iord;
  logic                 mem_read;
  logic                 mem_write;
  logic                 pc_src;
  logic                 j_src;
  logic                 reg_write;
  logic                 mem_to_reg;
  logic                 alu_src_a;
  logic                 is_lhi;
  logic                 set_wwd;
  logic [1:0]           reg_dest;
  logic [1:0]           alu_src_b;
  logic [2:0]           alu_op;

  modport master (
    input  inst, bcond, mem_ready,
    output mem_req, pc_write, ir_write, iord, mem_read, mem_write, pc_src,
           j_src, reg_write, mem_to_reg, alu_src_a, is_lhi, set_wwd,
           reg_dest, alu_src_b, alu_op
  );

  modport slave (
    output inst, bcond, mem_ready,
    input  mem_req, pc_write, ir_write, iord, mem_read, mem_write, pc_src,
           j_src, reg_write, mem_to_reg, alu_src_a, is_lhi, set_wwd,
           reg_dest, alu_src_b, alu_op
  );

endinterface

// File: rtl/mc_control_fsm_decode.sv
// mc_ctrl_decode: purely combinational instruction decode. Maps opcode/func
// to an instruction class and evaluates the branch condition on bcond.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic [WORD_SIZE-1:0] inst_i,
  input  logic [WORD_SIZE-1:0] bcond_i,
  output inst_class_t          instClass_o,
  output logic                 branchTaken_o,
  output logic                 branchZeroB_o,
  output logic [2:0]           aluFunc_o
);

  logic [3:0] opcode;
  logic [5:0] func;
  logic       bcondZero;
  logic       bcondNeg;
  logic       unusedInstBits;

  assign opcode         = inst_i[WORD_SIZE-1 -: 4];
  assign func           = inst_i[5:0];
  assign aluFunc_o      = func[2:0];
  assign bcondZero      = (bcond_i == '0);
  assign bcondNeg       = bcond_i[WORD_SIZE-1];
  assign branchZeroB_o  = (opcode == OP_BGZ) || (opcode == OP_BLZ);
  assign unusedInstBits = ^inst_i[WORD_SIZE-5:6];

  // Classify the instruction; unknown opcodes and funcs fall into CLS_UNDEF
  always_comb begin
    instClass_o = CLS_UNDEF;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: instClass_o = CLS_BRANCH;
      OP_ADI: instClass_o = CLS_ADI;
      OP_ORI: instClass_o = CLS_ORI;
      OP_LHI: instClass_o = CLS_LHI;
      OP_LWD: instClass_o = CLS_LWD;
      OP_SWD: instClass_o = CLS_SWD;
      OP_JMP: instClass_o = CLS_JMP;
      OP_JAL: instClass_o = CLS_JAL;
      OP_ALU: begin
        if (func < FN_ALU_LIMIT) begin
          instClass_o = CLS_RALU;
        end else begin
          case (func)
            FN_JPR:  instClass_o = CLS_JPR;
            FN_JRL:  instClass_o = CLS_JRL;
            FN_WWD:  instClass_o = CLS_WWD;
            FN_HLT:  instClass_o = CLS_HLT;
            default: instClass_o = CLS_UNDEF;
          endcase
        end
      end
      default: instClass_o = CLS_UNDEF;
    endcase
  end

  // Branch decision with bcond treated as a signed value
  always_comb begin
    branchTaken_o = 1'b0;
    case (opcode)
      OP_BNE:  branchTaken_o = !bcondZero;
      OP_BEQ:  branchTaken_o = bcondZero;
      OP_BGZ:  branchTaken_o = !bcondNeg && !bcondZero;
      OP_BLZ:  branchTaken_o = bcondNeg;
      default: branchTaken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle IF/ID/EX/MEM/WB controller with a memory
// request/ready handshake, a sticky HALT state and a retired-instruction
// counter. Defining CTRL_CYCLE_COUNT_EN adds cycle_count_o, a free-running
// count of non-HALT cycles.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  mc_control_fsm_if.master   bus,
  output logic [COUNT_W-1:0] num_inst_o,
  output logic               is_halted_o
`ifdef CTRL_CYCLE_COUNT_EN
  ,
  output logic [COUNT_W-1:0] cycle_count_o
`endif
);

  state_t             state_q;
  state_t             state_d;
  logic               retire_d;
  logic [COUNT_W-1:0] numInst_q;
`ifdef CTRL_CYCLE_COUNT_EN
  logic [COUNT_W-1:0] cycleCount_q;
`endif

  inst_class_t instClass;
  logic        branchTaken;
  logic        branchZeroB;
  logic [2:0]  aluFunc;

  mc_ctrl_decode #(
    .WORD_SIZE(WORD_SIZE)
  ) u_decode (
    .inst_i       (bus.inst),
    .bcond_i      (bus.bcond),
    .instClass_o  (instClass),
    .branchTaken_o(branchTaken),
    .branchZeroB_o(branchZeroB),
    .aluFunc_o    (aluFunc)
  );

  assign num_inst_o  = numInst_q;
  assign is_halted_o = (state_q == S_HALT);
`ifdef CTRL_CYCLE_COUNT_EN
  assign cycle_count_o = cycleCount_q;
`endif

  // Next state and retirement; memory states wait for mem_ready
  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    case (state_q)
      S_IF: begin
        if (bus.mem_ready) state_d = S_ID;
      end
      S_ID: begin
        if (instClass == CLS_HLT) begin
          state_d  = S_HALT;
          retire_d = 1'b1;
        end else if (classUsesEx(instClass)) begin
          state_d = S_EX;
        end else begin
          state_d  = S_IF;
          retire_d = 1'b1;
        end
      end
      S_EX: begin
        if (instClass == CLS_BRANCH) begin
          state_d  = S_IF;
          retire_d = 1'b1;
        end else if (instClass == CLS_LWD || instClass == CLS_SWD) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (instClass == CLS_LWD) begin
            state_d = S_WB;
          end else begin
            state_d  = S_IF;
            retire_d = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d  = S_IF;
        retire_d = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // State register and counters; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IF;
      numInst_q <= '0;
`ifdef CTRL_CYCLE_COUNT_EN
      cycleCount_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (retire_d) numInst_q <= numInst_q + 1'b1;
`ifdef CTRL_CYCLE_COUNT_EN
      if (state_q != S_HALT) cycleCount_q <= cycleCount_q + 1'b1;
`endif
    end
  end

  // Datapath strobes from current state and decode; all quiet during reset
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.pc_src     = 1'b0;
    bus.j_src      = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.is_lhi     = 1'b0;
    bus.set_wwd    = 1'b0;
    bus.reg_dest   = RD_RT;
    bus.alu_src_b  = SB_B;
    bus.alu_op     = ALU_ADD;
    if (reset_n) begin
      case (state_q)
        S_IF: begin
          bus.mem_req   = 1'b1;
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SB_ONE;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
          end
        end
        S_ID: begin
          bus.alu_src_b = SB_IMM;
          case (instClass)
            CLS_JMP: begin
              bus.pc_write = 1'b1;
              bus.pc_src   = 1'b1;
            end
            CLS_JAL: begin
              bus.pc_write  = 1'b1;
              bus.pc_src    = 1'b1;
              bus.reg_write = 1'b1;
              bus.reg_dest  = RD_R2;
            end
            CLS_JPR: begin
              bus.pc_write = 1'b1;
              bus.pc_src   = 1'b1;
              bus.j_src    = 1'b1;
            end
            CLS_JRL: begin
              bus.pc_write  = 1'b1;
              bus.pc_src    = 1'b1;
              bus.j_src     = 1'b1;
              bus.reg_write = 1'b1;
              bus.reg_dest  = RD_R2;
            end
            CLS_WWD: bus.set_wwd = 1'b1;
            default: ;
          endcase
        end
        S_EX: begin
          bus.alu_src_a = 1'b1;
          case (instClass)
            CLS_RALU: begin
              bus.alu_op    = aluFunc;
              bus.alu_src_b = SB_B;
            end
            CLS_ADI, CLS_LWD, CLS_SWD: begin
              bus.alu_op    = ALU_ADD;
              bus.alu_src_b = SB_IMM;
            end
            CLS_ORI: begin
              bus.alu_op    = ALU_ORR;
              bus.alu_src_b = SB_IMM;
            end
            CLS_LHI: begin
              bus.is_lhi    = 1'b1;
              bus.alu_src_b = SB_IMM;
            end
            CLS_BRANCH: begin
              bus.alu_op    = ALU_SUB;
              bus.alu_src_b = branchZeroB ? SB_ZERO : SB_B;
              bus.pc_write  = branchTaken;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.mem_req   = 1'b1;
          bus.iord      = 1'b1;
          bus.mem_read  = (instClass == CLS_LWD);
          bus.mem_write = (instClass == CLS_SWD);
        end
        S_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = (instClass == CLS_LWD);
          bus.reg_dest   = (instClass == CLS_RALU) ? RD_RD : RD_RT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: scoreboard bench for mc_control_fsm (COUNT_W=4 so the
// retired-instruction counter wraps quickly). Per-cycle expected strobe
// words are queued when an instruction is issued and compared as the DUT
// steps through it; counters are compared at each instruction boundary.
module tb_mc_control_fsm;

  localparam int PH_IF   = 0;
  localparam int PH_ID   = 1;
  localparam int PH_EX   = 2;
  localparam int PH_MEM  = 3;
  localparam int PH_WB   = 4;
  localparam int PH_HALT = 5;

  typedef struct {
    logic        rdy;
    logic [15:0] in;
    logic [19:0] word;
    int          ph;
  } cycExp_t;

  logic       clk;
  logic       reset_n;
  logic [3:0] numInst;
  logic       isHalted;
`ifdef CTRL_CYCLE_COUNT_EN
  logic [3:0] cycleCount;
`endif

  int         checks;
  int         failures;
  logic [3:0] expNum;
  logic [3:0] expCyc;
  cycExp_t    sbQ[$];

  mc_control_fsm_if #(.WORD_SIZE(16)) bus ();

  mc_control_fsm #(
    .WORD_SIZE(16),
    .COUNT_W  (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .num_inst_o (numInst),
    .is_halted_o(isHalted)
`ifdef CTRL_CYCLE_COUNT_EN
    ,
    .cycle_count_o(cycleCount)
`endif
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the stimulus ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] observedWord();
    return {bus.mem_req, bus.pc_write, bus.ir_write, bus.iord, bus.mem_read,
            bus.mem_write, bus.pc_src, bus.j_src, bus.reg_write, bus.mem_to_reg,
            bus.alu_src_a, bus.is_lhi, bus.set_wwd, bus.reg_dest, bus.alu_src_b,
            bus.alu_op};
  endfunction

  // Expected strobe word for one cycle, written from the behavioural description
  function automatic logic [19:0] expWord(input int ph, input logic [15:0] in,
                                          input logic [15:0] bc, input logic rdy);
    logic mreq, pcw, irw, iord, mrd, mwr, psrc, jsrc, rw, m2r, srca, lhi, wwd;
    logic [1:0] rd, srcb;
    logic [2:0] aop;
    logic [3:0] op;
    logic [5:0] fn;
    logic isR, tk;
    mreq = 0; pcw = 0; irw = 0; iord = 0; mrd = 0; mwr = 0; psrc = 0;
    jsrc = 0; rw = 0; m2r = 0; srca = 0; lhi = 0; wwd = 0;
    rd = 2'd0; srcb = 2'd0; aop = 3'd0; tk = 0;
    op = in[15:12];
    fn = in[5:0];
    isR = (op == 4'd15) && (fn < 6'd8);
    case (ph)
      PH_IF: begin
        mreq = 1; mrd = 1; srcb = 2'd1;
        if (rdy) begin irw = 1; pcw = 1; end
      end
      PH_ID: begin
        srcb = 2'd2;
        if (op == 4'd9 || op == 4'd10) begin pcw = 1; psrc = 1; end
        if (op == 4'd15 && (fn == 6'd25 || fn == 6'd26)) begin pcw = 1; psrc = 1; jsrc = 1; end
        if (op == 4'd10 || (op == 4'd15 && fn == 6'd26)) begin rw = 1; rd = 2'd2; end
        if (op == 4'd15 && fn == 6'd28) wwd = 1;
      end
      PH_EX: begin
        srca = 1;
        if (isR) begin
          aop = fn[2:0]; srcb = 2'd0;
        end else if (op == 4'd4 || op == 4'd7 || op == 4'd8) begin
          srcb = 2'd2;
        end else if (op == 4'd5) begin
          aop = 3'd3; srcb = 2'd2;
        end else if (op == 4'd6) begin
          lhi = 1; srcb = 2'd2;
        end else if (op <= 4'd3) begin
          aop = 3'd1;
          srcb = (op <= 4'd1) ? 2'd0 : 2'd3;
          case (op)
            4'd0: tk = (bc != 16'h0000);
            4'd1: tk = (bc == 16'h0000);
            4'd2: tk = ($signed(bc) > $signed(16'h0000));
            default: tk = ($signed(bc) < $signed(16'h0000));
          endcase
          pcw = tk;
        end
      end
      PH_MEM: begin
        mreq = 1; iord = 1;
        mrd = (op == 4'd7);
        mwr = (op == 4'd8);
      end
      PH_WB: begin
        rw = 1;
        m2r = (op == 4'd7);
        rd = isR ? 2'd1 : 2'd0;
      end
      default: ;
    endcase
    return {mreq, pcw, irw, iord, mrd, mwr, psrc, jsrc, rw, m2r, srca, lhi, wwd, rd, srcb, aop};
  endfunction

  task automatic pushCycle(input int ph, input logic [15:0] in, input logic [15:0] bc, input logic rdy);
    cycExp_t item;
    item.rdy  = rdy;
    item.in   = in;
    item.word = expWord(ph, in, bc, rdy);
    item.ph   = ph;
    sbQ.push_back(item);
  endtask

  // Drive queued cycles one by one and compare each against the DUT
  task automatic drainScoreboard(input string tag);
    cycExp_t item;
    int n;
    n = 0;
    while (sbQ.size() > 0) begin
      item = sbQ.pop_front();
      bus.inst      = item.in;
      bus.mem_ready = item.rdy;
      @(negedge clk);
      checkOutput($sformatf("%s.cyc%0d", tag, n), 32'(observedWord()), 32'(item.word));
      if (item.ph != PH_HALT) expCyc = expCyc + 4'd1;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic checkCounters(input string tag, input logic expHalt);
    checkOutput({tag, ".num_inst"}, 32'(numInst), 32'(expNum));
    checkOutput({tag, ".halted"}, 32'(isHalted), 32'(expHalt));
`ifdef CTRL_CYCLE_COUNT_EN
    checkOutput({tag, ".cycle_count"}, 32'(cycleCount), 32'(expCyc));
`endif
  endtask

  // Issue one instruction with the given fetch/data wait states
  task automatic applyStimulus(input string tag, input logic [15:0] in, input logic [15:0] bc,
                               input int ifWaits, input int memWaits);
    logic [3:0] op;
    logic [5:0] fn;
    logic useEx, useMem, useWb, halts;
    op = in[15:12];
    fn = in[5:0];
    useEx  = (op <= 4'd8) || (op == 4'd15 && fn < 6'd8);
    useMem = (op == 4'd7) || (op == 4'd8);
    useWb  = (op >= 4'd4 && op <= 4'd7) || (op == 4'd15 && fn < 6'd8);
    halts  = (op == 4'd15) && (fn == 6'd29);
    bus.bcond = bc;
    for (int i = 0; i <= ifWaits; i++) pushCycle(PH_IF, in, bc, (i == ifWaits));
    pushCycle(PH_ID, in, bc, 1'($urandom_range(0, 1)));
    if (useEx) pushCycle(PH_EX, in, bc, 1'($urandom_range(0, 1)));
    if (useMem) for (int i = 0; i <= memWaits; i++) pushCycle(PH_MEM, in, bc, (i == memWaits));
    if (useWb) pushCycle(PH_WB, in, bc, 1'($urandom_range(0, 1)));
    expNum = expNum + 4'd1;
    drainScoreboard(tag);
    checkCounters(tag, halts);
  endtask

  // Keep running in HALT with changing inputs; nothing may move
  task automatic holdHalted(input int cycles);
    for (int i = 0; i < cycles; i++)
      pushCycle(PH_HALT, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    drainScoreboard("halt");
    checkCounters("halt", 1'b1);
  endtask

  // Hold reset low for some edges, then check the cleared state
  task automatic applyReset(input int edges);
    reset_n = 1'b0;
    repeat (edges) @(posedge clk);
    #1;
    expNum = 4'd0;
    expCyc = 4'd0;
    checkOutput("reset.strobes", 32'(observedWord()), 32'd0);
    checkCounters("reset", 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    expNum = 4'd0;
    expCyc = 4'd0;
    reset_n = 1'b0;
    bus.inst = 16'h0000;
    bus.bcond = 16'h0000;
    bus.mem_ready = 1'b1;

    applyReset(2);

    applyStimulus("add",      16'hF6C0, 16'h1234, 0, 0);
    applyStimulus("lwd",      16'h7405, 16'h0000, 2, 3);
    applyStimulus("beq_t",    16'h1002, 16'h0000, 0, 0);
    applyStimulus("blz_nt",   16'h3004, 16'h0001, 0, 0);
    applyStimulus("jrl",      16'hF41A, 16'h0000, 0, 0);
    applyStimulus("swd",      16'h8203, 16'h0000, 1, 2);
    applyStimulus("adi",      16'h4107, 16'h0000, 0, 0);
    applyStimulus("ori",      16'h5210, 16'h0000, 1, 0);
    applyStimulus("lhi",      16'h6055, 16'h0000, 0, 0);
    applyStimulus("sub",      16'hF6C1, 16'h0000, 0, 0);
    applyStimulus("shr",      16'hF6C7, 16'h0000, 0, 0);
    applyStimulus("bne_t",    16'h0001, 16'h0005, 0, 0);
    applyStimulus("bne_nt",   16'h0001, 16'h0000, 0, 0);
    applyStimulus("bgz_nt",   16'h2001, 16'h8000, 0, 0);
    applyStimulus("bgz_t",    16'h2001, 16'h0003, 0, 0);
    applyStimulus("blz_t",    16'h3001, 16'hFFFF, 0, 0);
    applyStimulus("jmp",      16'h9123, 16'h0000, 0, 0);
    applyStimulus("jal",      16'hA010, 16'h0000, 2, 0);
    applyStimulus("jpr",      16'hF819, 16'h0000, 0, 0);
    applyStimulus("wwd",      16'hF01C, 16'h0000, 0, 0);
    applyStimulus("undef_op", 16'hB000, 16'h0000, 0, 0);
    applyStimulus("undef_fn", 16'hF020, 16'h0000, 0, 0);
    applyStimulus("hlt",      16'hF01D, 16'h0000, 0, 0);
    holdHalted(20);

    applyReset(1);
    for (int k = 0; k < 17; k++) applyStimulus($sformatf("wrap%0d", k), 16'hF01C, 16'h0000, 1, 0);
    checkOutput("wrap.num_inst_final", 32'(numInst), 32'd1);

    bus.inst = 16'h7405;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("midacc.mem_req", 32'(bus.mem_req), 32'd1);
    @(posedge clk);
    #1;
    applyReset(1);
    applyStimulus("after_rst", 16'hF6C0, 16'h0000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
